if_fetch: RTL and testbench

- Instruction-fetch front end: owns the PC, issues requests on the instruction-memory bus, and buffers returned instructions for the if_id pipeline register.
- Consumes the pipeline hold vector and predict-fail flag from the pipeline controller. Also consumes the ID-stage predicted jump and the EX-stage resolved jump.
- Handles redirects by bumping a fetch epoch, so responses still in flight from the wrong path are discarded.

---
 rtl/if_fetch.sv | 86 ++++++++
 tb/tb_if_fetch.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch.sv
// if_fetch: instruction-fetch front end (PC, imem requests, epoch-tagged in-flight tracking, fetch buffer to if_id); ports: clk/rstn, hold/redirect inputs, imem req/gnt/rvalid bus, inst_o/inst_addr_o/inst_valid_o head of buffer
module if_fetch #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          BUF_DEPTH = 2,
  parameter logic [31:0] NOP_INST  = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [4:0]  hold_en_i,
  input  logic        prd_fail_i,
  input  logic        ex_jump_en_i,
  input  logic [31:0] ex_jump_addr_i,
  input  logic [31:0] ex_pc_i,
  input  logic        prd_jump_en_i,
  input  logic [31:0] prd_jump_addr_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic [31:0] inst_o,
  output logic [31:0] inst_addr_o,
  output logic        inst_valid_o
);
  localparam int AW = $clog2(BUF_DEPTH);
  localparam int CW = AW + 1;
  logic [31:0] pc, pc_next, last_pc, redirect_pc;
  logic epoch, redirect, grant, rsp, buf_push, buf_pop;
  logic [32:0] tag_q [BUF_DEPTH];
  logic [63:0] buf_q [BUF_DEPTH];
  logic [AW-1:0] tag_wp, tag_rp, buf_wp, buf_rp;
  logic [CW-1:0] out_cnt, buf_cnt;
  logic [CW:0] credit;
  logic unused_hold;
  assign unused_hold = ^hold_en_i[4:2];
  always_comb begin
    redirect = prd_fail_i | prd_jump_en_i;
    redirect_pc = prd_fail_i ? (ex_jump_en_i ? ex_jump_addr_i : ex_pc_i + 32'd4) : prd_jump_addr_i;
    credit = {1'b0, out_cnt} + {1'b0, buf_cnt};
    imem_req_o = rstn & !hold_en_i[0] & !redirect & (credit < (CW+1)'(BUF_DEPTH));
    imem_addr_o = {pc[31:2], 2'b00};
    grant = imem_req_o & imem_gnt_i;
    rsp = imem_rvalid_i & (out_cnt != '0);
    buf_push = rsp & !redirect & (tag_q[tag_rp][32] == epoch);
    inst_valid_o = buf_cnt != '0;
    buf_pop = inst_valid_o & !hold_en_i[1] & !redirect;
    inst_o = inst_valid_o ? buf_q[buf_rp][31:0] : NOP_INST;
    inst_addr_o = inst_valid_o ? buf_q[buf_rp][63:32] : last_pc;
    pc_next = redirect ? redirect_pc : grant ? pc + 32'd4 : pc;
  end
  always_ff @(posedge clk) begin
    if (grant) tag_q[tag_wp] <= {epoch, imem_addr_o};
    if (buf_push) buf_q[buf_wp] <= {tag_q[tag_rp][31:0], imem_rdata_i};
  end
  always_ff @(posedge clk) begin
    if (!rstn) begin
      pc      <= RESET_PC;
      last_pc <= RESET_PC;
      epoch   <= 1'b0;
      tag_wp  <= '0;
      tag_rp  <= '0;
      out_cnt <= '0;
      buf_wp  <= '0;
      buf_rp  <= '0;
      buf_cnt <= '0;
    end else begin
      pc      <= pc_next;
      epoch   <= epoch ^ redirect;
      out_cnt <= out_cnt + CW'(grant) - CW'(rsp);
      if (grant) tag_wp <= tag_wp + AW'(1);
      if (rsp) tag_rp <= tag_rp + AW'(1);
      if (buf_push) buf_wp <= buf_wp + AW'(1);
      if (buf_pop) last_pc <= buf_q[buf_rp][63:32];
      // a flush realigns the read pointer instead of resetting both, so no push is lost mid-write
      if (redirect) begin
        buf_rp  <= buf_wp;
        buf_cnt <= '0;
      end else begin
        if (buf_pop) buf_rp <= buf_rp + AW'(1);
        buf_cnt <= buf_cnt + CW'(buf_push) - CW'(buf_pop);
      end
    end
  end
  assert property (@(posedge clk) disable iff (!rstn) !(buf_push && !buf_pop && buf_cnt == CW'(BUF_DEPTH)));
  assert property (@(posedge clk) disable iff (!rstn) !(grant && !rsp && out_cnt == CW'(BUF_DEPTH)));
endmodule

// File: tb/tb_if_fetch.sv
// tb_if_fetch: directed scenarios plus randomized run against a queue-based fetch model
module tb_if_fetch;
  localparam int BUF_DEPTH = 2;
  localparam logic [31:0] NOP = 32'h0000_0013;
  logic clk = 1'b0, rstn = 1'b0;
  logic [4:0] hold_en_i = '0;
  logic prd_fail_i = 0, ex_jump_en_i = 0, prd_jump_en_i = 0;
  logic [31:0] ex_jump_addr_i = '0, ex_pc_i = '0, prd_jump_addr_i = '0;
  logic imem_req_o, imem_gnt_i = 0, imem_rvalid_i = 0, inst_valid_o;
  logic [31:0] imem_addr_o, imem_rdata_i = '0, inst_o, inst_addr_o;
  int n_checks = 0, n_fail = 0, gnt_pct = 0, rv_pct = 0;
  logic [31:0] pend[$];

  if_fetch #(.RESET_PC(32'h0), .BUF_DEPTH(BUF_DEPTH), .NOP_INST(NOP)) dut (
    .clk(clk), .rstn(rstn), .hold_en_i(hold_en_i), .prd_fail_i(prd_fail_i),
    .ex_jump_en_i(ex_jump_en_i), .ex_jump_addr_i(ex_jump_addr_i), .ex_pc_i(ex_pc_i),
    .prd_jump_en_i(prd_jump_en_i), .prd_jump_addr_i(prd_jump_addr_i),
    .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o), .imem_gnt_i(imem_gnt_i),
    .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i),
    .inst_o(inst_o), .inst_addr_o(inst_addr_o), .inst_valid_o(inst_valid_o));

  always #5 clk = ~clk;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
  endfunction

  function automatic logic [31:0] pick();
    logic [31:0] v;
    int r;
    v = $urandom;
    r = $urandom_range(5);
    return r == 0 ? 32'hFFFF_FFFC : r == 1 ? 32'hFFFF_FFF8 : {v[31:2], 2'b00};
  endfunction

  // memory responder: in-order responses, at least one cycle after grant
  task automatic tick();
    @(negedge clk);
    if (imem_rvalid_i && pend.size() != 0) void'(pend.pop_front());
    if (imem_req_o && imem_gnt_i) pend.push_back(imem_addr_o);
    @(posedge clk);
    #1;
    imem_rvalid_i = pend.size() != 0 && $urandom_range(99) < rv_pct;
    imem_rdata_i = imem_rvalid_i ? memf(pend[0]) : $urandom;
    imem_gnt_i = $urandom_range(99) < gnt_pct;
  endtask

  task automatic do_reset();
    rstn = 0; hold_en_i = '0; prd_fail_i = 0; prd_jump_en_i = 0; ex_jump_en_i = 0;
    gnt_pct = 0; rv_pct = 0; imem_gnt_i = 0; imem_rvalid_i = 0; pend.delete();
    tick(); tick();
    rstn = 1;
  endtask

  task automatic test_reset();
    rstn = 0; hold_en_i = 5'b00001; imem_gnt_i = 0; imem_rvalid_i = 0; pend.delete();
    #2;
    n_checks++; if (imem_req_o !== 1'b0) begin n_fail++; $display("FAIL reset_req_low got %b want 0", imem_req_o); end
    tick(); tick();
    rstn = 1;
    #2;
    n_checks++; if (inst_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", inst_valid_o); end
    n_checks++; if (inst_o !== NOP) begin n_fail++; $display("FAIL reset_inst got %h want %h", inst_o, NOP); end
    n_checks++; if (inst_addr_o !== 32'h0) begin n_fail++; $display("FAIL reset_inst_addr got %h want 0", inst_addr_o); end
    n_checks++; if (imem_addr_o !== 32'h0) begin n_fail++; $display("FAIL reset_imem_addr got %h want 0", imem_addr_o); end
    n_checks++; if (imem_req_o !== 1'b0) begin n_fail++; $display("FAIL reset_req_hold got %b want 0", imem_req_o); end
    hold_en_i = '0;
    #1;
    n_checks++; if (imem_req_o !== 1'b1) begin n_fail++; $display("FAIL reset_req_free got %b want 1", imem_req_o); end
    tick();
  endtask

  task automatic test_free_run();
    logic [31:0] ef, eo;
    int fg, fv;
    do_reset();
    gnt_pct = 100; rv_pct = 100; imem_gnt_i = 1;
    ef = 0; eo = 0; fg = -1; fv = -1;
    for (int c = 0; c < 30; c++) begin
      #2;
      if (inst_valid_o) begin
        if (fv < 0) fv = c;
        n_checks++; if (inst_addr_o !== eo || inst_o !== memf(eo)) begin n_fail++; $display("FAIL free_inst got %h/%h want %h/%h", inst_addr_o, inst_o, eo, memf(eo)); end
        eo += 4;
      end
      if (imem_req_o && imem_gnt_i) begin
        if (fg < 0) fg = c;
        n_checks++; if (imem_addr_o !== ef) begin n_fail++; $display("FAIL free_fetch_addr got %h want %h", imem_addr_o, ef); end
        ef += 4;
      end
      tick();
    end
    n_checks++; if (fv - fg != 2) begin n_fail++; $display("FAIL free_first_valid got %0d want 2", fv - fg); end
    n_checks++; if (eo < 32'd32) begin n_fail++; $display("FAIL free_progress got %0d want >=32", eo); end
  endtask

  task automatic test_hold();
    logic [31:0] gl, io, ia, pa;
    do_reset();
    gnt_pct = 100; rv_pct = 100; imem_gnt_i = 1; hold_en_i = 5'b00010; gl = 0;
    for (int c = 0; c < 6; c++) begin
      #2;
      if (imem_req_o && imem_gnt_i) gl = imem_addr_o;
      tick();
    end
    hold_en_i = 5'b00011;
    #2;
    n_checks++; if (inst_valid_o !== 1'b1) begin n_fail++; $display("FAIL hold_full_valid got %b want 1", inst_valid_o); end
    io = inst_o; ia = inst_addr_o; pa = imem_addr_o;
    n_checks++; if (ia !== 32'h0 || pa !== 32'h8) begin n_fail++; $display("FAIL hold_start got %h/%h want 0/8", ia, pa); end
    for (int c = 0; c < 3; c++) begin
      #1;
      n_checks++; if (imem_req_o !== 1'b0) begin n_fail++; $display("FAIL hold_req got %b want 0", imem_req_o); end
      n_checks++; if (inst_o !== io || inst_addr_o !== ia) begin n_fail++; $display("FAIL hold_stable got %h/%h want %h/%h", inst_o, inst_addr_o, io, ia); end
      n_checks++; if (imem_addr_o !== pa) begin n_fail++; $display("FAIL hold_pc got %h want %h", imem_addr_o, pa); end
      tick();
    end
    hold_en_i = '0;
    #2;
    n_checks++; if (imem_req_o !== 1'b0 && imem_addr_o !== gl + 4) begin n_fail++; $display("FAIL hold_resume got %h want %h", imem_addr_o, gl + 4); end
    n_checks++; if (imem_addr_o !== gl + 4) begin n_fail++; $display("FAIL hold_resume_addr got %h want %h", imem_addr_o, gl + 4); end
    tick();
  endtask

  task automatic test_prd_jump();
    bit found;
    do_reset();
    gnt_pct = 100; rv_pct = 0; imem_gnt_i = 1;
    tick(); tick();
    prd_jump_en_i = 1; prd_jump_addr_i = 32'h100;
    #2;
    n_checks++; if (imem_req_o !== 1'b0) begin n_fail++; $display("FAIL jump_req got %b want 0", imem_req_o); end
    tick();
    prd_jump_en_i = 0;
    #2;
    n_checks++; if (imem_addr_o !== 32'h100) begin n_fail++; $display("FAIL jump_addr got %h want 100", imem_addr_o); end
    n_checks++; if (inst_valid_o !== 1'b0) begin n_fail++; $display("FAIL jump_flush got %b want 0", inst_valid_o); end
    rv_pct = 100; found = 0;
    for (int c = 0; c < 20 && !found; c++) begin
      #1;
      if (inst_valid_o) begin
        found = 1;
        n_checks++; if (inst_addr_o !== 32'h100 || inst_o !== memf(32'h100)) begin n_fail++; $display("FAIL jump_first got %h/%h want 100/%h", inst_addr_o, inst_o, memf(32'h100)); end
      end
      tick();
    end
    if (!found) begin n_checks++; n_fail++; $display("FAIL jump_timeout got none want valid"); end
  endtask

  task automatic test_prd_fail();
    do_reset();
    gnt_pct = 100; rv_pct = 100; imem_gnt_i = 1; hold_en_i = 5'b00010;
    repeat (4) tick();
    rv_pct = 0; imem_rvalid_i = 0;
    prd_fail_i = 1; ex_jump_en_i = 0; ex_pc_i = 32'h200; ex_jump_addr_i = 32'h7770; hold_en_i = 5'b00111;
    #2;
    n_checks++; if (inst_valid_o !== 1'b1) begin n_fail++; $display("FAIL fail_pre_valid got %b want 1", inst_valid_o); end
    n_checks++; if (imem_req_o !== 1'b0) begin n_fail++; $display("FAIL fail_req got %b want 0", imem_req_o); end
    tick();
    prd_fail_i = 0;
    #2;
    n_checks++; if (imem_addr_o !== 32'h204) begin n_fail++; $display("FAIL fail_addr got %h want 204", imem_addr_o); end
    n_checks++; if (inst_valid_o !== 1'b0) begin n_fail++; $display("FAIL fail_flush got %b want 0", inst_valid_o); end
    tick();
  endtask

  task automatic test_both();
    do_reset();
    prd_fail_i = 1; ex_jump_en_i = 1; ex_jump_addr_i = 32'h300; ex_pc_i = 32'h500;
    prd_jump_en_i = 1; prd_jump_addr_i = 32'h400;
    tick();
    prd_fail_i = 0; prd_jump_en_i = 0; ex_jump_en_i = 0;
    #2;
    n_checks++; if (imem_addr_o !== 32'h300) begin n_fail++; $display("FAIL both_addr got %h want 300", imem_addr_o); end
    n_checks++; if (imem_req_o !== 1'b1) begin n_fail++; $display("FAIL both_req got %b want 1", imem_req_o); end
    tick();
  endtask

  task automatic test_wrap();
    do_reset();
    prd_jump_en_i = 1; prd_jump_addr_i = 32'hFFFF_FFFC;
    tick();
    prd_jump_en_i = 0; imem_gnt_i = 1;
    #2;
    n_checks++; if (imem_addr_o !== 32'hFFFF_FFFC || imem_req_o !== 1'b1) begin n_fail++; $display("FAIL wrap_top got %h/%b want fffffffc/1", imem_addr_o, imem_req_o); end
    tick();
    #2;
    n_checks++; if (imem_addr_o !== 32'h0) begin n_fail++; $display("FAIL wrap_zero got %h want 0", imem_addr_o); end
    tick();
  endtask

  task automatic test_reset_midflight();
    do_reset();
    gnt_pct = 100; rv_pct = 0; imem_gnt_i = 1;
    tick(); tick();
    gnt_pct = 0; imem_gnt_i = 0; rstn = 0; hold_en_i = 5'b00001;
    tick();
    rstn = 1; rv_pct = 100;
    for (int c = 0; c < 3; c++) begin
      #2;
      n_checks++; if (inst_valid_o !== 1'b0) begin n_fail++; $display("FAIL midreset_valid got %b want 0", inst_valid_o); end
      tick();
    end
    hold_en_i = '0;
    #2;
    n_checks++; if (imem_addr_o !== 32'h0 || imem_req_o !== 1'b1) begin n_fail++; $display("FAIL midreset_restart got %h/%b want 0/1", imem_addr_o, imem_req_o); end
    tick();
  endtask

  task automatic test_random();
    logic [32:0] m_fl[$];
    logic [31:0] m_q[$];
    logic [31:0] m_pc, m_last, tgt, f;
    logic m_ep, redir, ev, er;
    logic [32:0] t;
    do_reset();
    m_pc = 0; m_last = 0; m_ep = 0;
    gnt_pct = 60; rv_pct = 60;
    for (int c = 0; c < 2000; c++) begin
      prd_jump_en_i = $urandom_range(99) < 4; prd_jump_addr_i = pick();
      prd_fail_i = $urandom_range(99) < 3; ex_jump_en_i = $urandom_range(1) == 1;
      ex_jump_addr_i = pick(); ex_pc_i = pick();
      hold_en_i = $urandom_range(99) < 20 ? 5'($urandom) : 5'b0;
      #2;
      redir = prd_fail_i || prd_jump_en_i;
      tgt = prd_fail_i ? (ex_jump_en_i ? ex_jump_addr_i : ex_pc_i + 32'd4) : prd_jump_addr_i;
      ev = m_q.size() != 0;
      f = ev ? m_q[0] : m_last;
      er = !hold_en_i[0] && !redir && (m_fl.size() + m_q.size() < BUF_DEPTH);
      n_checks++; if (inst_valid_o !== ev) begin n_fail++; $display("FAIL rnd_valid c%0d got %b want %b", c, inst_valid_o, ev); end
      n_checks++; if (inst_addr_o !== f) begin n_fail++; $display("FAIL rnd_inst_addr c%0d got %h want %h", c, inst_addr_o, f); end
      n_checks++; if (inst_o !== (ev ? memf(f) : NOP)) begin n_fail++; $display("FAIL rnd_inst c%0d got %h want %h", c, inst_o, ev ? memf(f) : NOP); end
      n_checks++; if (imem_req_o !== er) begin n_fail++; $display("FAIL rnd_req c%0d got %b want %b", c, imem_req_o, er); end
      n_checks++; if (imem_addr_o !== {m_pc[31:2], 2'b00}) begin n_fail++; $display("FAIL rnd_fetch_addr c%0d got %h want %h", c, imem_addr_o, {m_pc[31:2], 2'b00}); end
      if (imem_rvalid_i && m_fl.size() != 0) begin
        t = m_fl.pop_front();
        if (t[32] == m_ep && !redir) m_q.push_back(t[31:0]);
      end
      if (ev && !hold_en_i[1] && !redir) m_last = m_q.pop_front();
      if (redir) begin
        m_q.delete(); m_ep = !m_ep; m_pc = tgt;
      end else if (er && imem_gnt_i) begin
        m_fl.push_back({m_ep, m_pc[31:2], 2'b00}); m_pc = m_pc + 32'd4;
      end
      tick();
    end
    prd_jump_en_i = 0; prd_fail_i = 0; hold_en_i = '0;
  endtask

  initial begin
    test_reset();
    test_free_run();
    test_hold();
    test_prd_jump();
    test_prd_fail();
    test_both();
    test_wrap();
    test_reset_midflight();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end
endmodule
